// File: rtl/line_mem_responder.sv
// Cache-line memory responder: round-robin I/D arbitration in front of a
// single-port XLEN-wide SRAM, moving one word beat per cycle.
module line_mem_responder #(
    parameter int XLEN      = 32,
    parameter int CLSIZE    = 128,
    parameter int MEM_WORDS = 16384
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              i_strobe_i,
    input  logic [XLEN-1:0]   i_addr_i,
    output logic              i_done_o,
    output logic [CLSIZE-1:0] i_data_o,
    input  logic              d_strobe_i,
    input  logic [XLEN-1:0]   d_addr_i,
    input  logic              d_rw_i,
    input  logic [CLSIZE-1:0] d_data_i,
    output logic              d_done_o,
    output logic [CLSIZE-1:0] d_data_o,
    output logic              busy_o
);
    localparam int NBEAT  = CLSIZE / XLEN;
    localparam int AW     = $clog2(MEM_WORDS);
    localparam int BOFF   = $clog2(XLEN / 8);
    localparam int LOFF   = $clog2(CLSIZE / 8);
    localparam int BW     = $clog2(NBEAT);
    localparam int IW     = AW - BW;
    localparam int CW     = $clog2(NBEAT + 1);
    localparam int IDX_HI = AW + BOFF - 1;
    localparam logic [CW-1:0] LAST_RD = CW'(NBEAT);
    localparam logic [CW-1:0] LAST_WR = CW'(NBEAT - 1);

    // Handshake: a requester raises strobe with a stable addr (and rw/data on
    // the D side) and holds it until its one-cycle done pulse; strobes are
    // only sampled in IDLE, so a strobe seen there is always a fresh request.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              side_q, side_d;            // 1 = D side
    logic              last_grant_q, last_grant_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CLSIZE-1:0] wdata_q, wdata_d;
    logic [CLSIZE-1:0] line_q, line_d;
    logic [CLSIZE-1:0] i_data_q, i_data_d;
    logic [CLSIZE-1:0] d_data_q, d_data_d;

    logic              grant_d_side;
    logic              any_req;
    logic [CW-1:0]     cap_idx;
    logic              mem_en, mem_we;
    logic [AW-1:0]     mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   rdata_q;
    logic [XLEN-1:0]   mem_q [MEM_WORDS];
    logic              unused_addr;

    assign unused_addr = ^{i_addr_i[XLEN-1:IDX_HI+1], i_addr_i[LOFF-1:0],
                           d_addr_i[XLEN-1:IDX_HI+1], d_addr_i[LOFF-1:0]};

    // On a tie the side that did not win last time gets the grant.
    assign any_req      = i_strobe_i | d_strobe_i;
    assign grant_d_side = d_strobe_i & (~i_strobe_i | ~last_grant_q);
    assign cap_idx      = cnt_q - CW'(1);
    assign mem_addr     = {idx_q, cnt_q[BW-1:0]};
    assign mem_wdata    = wdata_q[cnt_q[BW-1:0]*XLEN +: XLEN];

    always_comb begin
        state_d      = state_q;
        side_d       = side_q;
        last_grant_d = last_grant_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        wdata_d      = wdata_q;
        line_d       = line_q;
        i_data_d     = i_data_q;
        d_data_d     = d_data_q;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    side_d       = grant_d_side;
                    last_grant_d = grant_d_side;
                    idx_d        = grant_d_side ? d_addr_i[IDX_HI:LOFF] : i_addr_i[IDX_HI:LOFF];
                    wdata_d      = d_data_i;
                    cnt_d        = '0;
                    state_d      = (grant_d_side & d_rw_i) ? S_WR : S_RD;
                end
            end
            S_RD: begin
                // Reads are issued for cnt 0..NBEAT-1; the registered SRAM
                // output is captured one cycle behind, for cnt 1..NBEAT.
                mem_en = (cnt_q != LAST_RD);
                if (cnt_q != '0) begin
                    line_d[cap_idx[BW-1:0]*XLEN +: XLEN] = rdata_q;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_RD) begin
                    state_d = S_RESP;
                    if (side_q) begin
                        d_data_d = line_d;
                    end else begin
                        i_data_d = line_d;
                    end
                end
            end
            S_WR: begin
                mem_en = 1'b1;
                mem_we = 1'b1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_WR) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            side_q       <= 1'b0;
            last_grant_q <= 1'b0;
            idx_q        <= '0;
            cnt_q        <= '0;
            wdata_q      <= '0;
            line_q       <= '0;
            i_data_q     <= '0;
            d_data_q     <= '0;
        end else begin
            state_q      <= state_d;
            side_q       <= side_d;
            last_grant_q <= last_grant_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            wdata_q      <= wdata_d;
            line_q       <= line_d;
            i_data_q     <= i_data_d;
            d_data_q     <= d_data_d;
        end
    end

    // Backing store is deliberately not reset; contents survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (mem_en) begin
            if (mem_we) begin
                mem_q[mem_addr] <= mem_wdata;
            end else begin
                rdata_q <= mem_q[mem_addr];
            end
        end
    end

    assign i_done_o = (state_q == S_RESP) & ~side_q;
    assign d_done_o = (state_q == S_RESP) & side_q;
    assign i_data_o = i_data_q;
    assign d_data_o = d_data_q;
    assign busy_o   = (state_q != S_IDLE);

endmodule
